// File: rtl/axi_multi_timer_pkg.sv
// Shared definitions for axi_multi_timer: register map, CTRL bit positions,
// response codes and the address decoder used by the write and read paths.
package axi_multi_timer_pkg;

  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_COUNT    = 4'h4;
  localparam logic [3:0] OFF_PRESCALE = 4'h8;
  localparam logic [3:0] OFF_COMPARE  = 4'hC;
  localparam logic [8:0] ADDR_STATUS  = 9'h100;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_CLR         = 1;
  localparam int CTRL_AUTO_RELOAD = 2;
  localparam int CTRL_IRQ_EN      = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_COUNT,
    SEL_PRESCALE,
    SEL_COMPARE,
    SEL_STATUS
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [3:0] ch;
  } reg_dec_t;

  // SEL_NONE marks any unmapped offset or a channel index beyond num_ch.
  function automatic reg_dec_t decode_addr(input logic [8:0] addr, input int num_ch);
    reg_dec_t d;
    d.sel = SEL_NONE;
    d.ch  = addr[7:4];
    if (addr == ADDR_STATUS) begin
      d.sel = SEL_STATUS;
    end else if (!addr[8] && (int'(addr[7:4]) < num_ch)) begin
      case (addr[3:0])
        OFF_CTRL:     d.sel = SEL_CTRL;
        OFF_COUNT:    d.sel = SEL_COUNT;
        OFF_PRESCALE: d.sel = SEL_PRESCALE;
        OFF_COMPARE:  d.sel = SEL_COMPARE;
        default:      d.sel = SEL_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/axi_multi_timer_channel.sv
// One timer channel: prescaler, counter with wrap or auto-reload, and a
// single-cycle match pulse when the counter equals COMPARE on a tick.
module timer_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             clr,
  input  logic [CNT_W-1:0] prescale,
  input  logic [CNT_W-1:0] compare,
  output logic [CNT_W-1:0] count,
  output logic             match
);

  logic [CNT_W-1:0] pre_cnt;
  logic             tick;

  assign tick  = en && (pre_cnt == prescale);
  assign match = tick && !clr && (count == compare);

  // A clear on the write edge overrides any tick landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      count   <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
      count   <= '0;
    end else if (en) begin
      if (tick) begin
        pre_cnt <= '0;
        count   <= (match && auto_reload) ? '0 : count + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_multi_timer.sv
// AXI4-Lite multi-channel timer. STATUS, per-channel IRQ_EN and irq exist
// only when AXI_MULTI_TIMER_IRQ_EN is defined; otherwise irq is tied low.
module axi_multi_timer
  import axi_multi_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic        s_bvalid,
  output logic [1:0]  s_bresp,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic        irq
);

`ifdef AXI_MULTI_TIMER_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'b1101;
`else
  localparam logic [3:0] CTRL_MASK = 4'b0101;
`endif

  logic [3:0]       ctrl_q     [NUM_CH];
  logic [CNT_W-1:0] prescale_q [NUM_CH];
  logic [CNT_W-1:0] compare_q  [NUM_CH];
  logic [CNT_W-1:0] count      [NUM_CH];
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] clr;

  logic        wr_fire;
  logic        rd_fire;
  reg_dec_t    wr_dec;
  reg_dec_t    rd_dec;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic        unused_addr;

  function automatic logic [CNT_W-1:0] lane_merge(input logic [CNT_W-1:0] old,
                                                  input logic [31:0]      data,
                                                  input logic [3:0]       strb);
    logic [CNT_W-1:0] r;
    for (int i = 0; i < CNT_W; i++) begin
      r[i] = strb[i/8] ? data[i] : old[i];
    end
    return r;
  endfunction

  assign s_awready   = 1'b1;
  assign s_wready    = 1'b1;
  assign s_arready   = 1'b1;
  assign unused_addr = ^{s_awaddr[31:9], s_araddr[31:9]};

  assign wr_fire = s_awvalid && s_wvalid && !s_bvalid;
  assign rd_fire = s_arvalid && !s_rvalid;
  assign wr_dec  = decode_addr(s_awaddr[8:0], NUM_CH);
  assign rd_dec  = decode_addr(s_araddr[8:0], NUM_CH);

  always_comb begin
    clr = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      clr[n] = wr_fire && (wr_dec.sel == SEL_CTRL) && (wr_dec.ch == 4'(n)) &&
               s_wstrb[0] && s_wdata[CTRL_CLR];
    end
  end

  // CLR is a strobe only, so it is masked out of the stored CTRL value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        ctrl_q[n]     <= '0;
        prescale_q[n] <= '0;
        compare_q[n]  <= '0;
      end
    end else if (wr_fire) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_dec.ch == 4'(n)) begin
          case (wr_dec.sel)
            SEL_CTRL:     if (s_wstrb[0]) ctrl_q[n] <= s_wdata[3:0] & CTRL_MASK;
            SEL_PRESCALE: prescale_q[n] <= lane_merge(prescale_q[n], s_wdata, s_wstrb);
            SEL_COMPARE:  compare_q[n]  <= lane_merge(compare_q[n], s_wdata, s_wstrb);
            default:      ;
          endcase
        end
      end
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en          (ctrl_q[n][CTRL_EN]),
      .auto_reload (ctrl_q[n][CTRL_AUTO_RELOAD]),
      .clr         (clr[n]),
      .prescale    (prescale_q[n]),
      .compare     (compare_q[n]),
      .count       (count[n]),
      .match       (match[n])
    );
  end

`ifdef AXI_MULTI_TIMER_IRQ_EN
  logic [NUM_CH-1:0] status_q;
  logic [NUM_CH-1:0] irq_en;
  logic              status_wr;

  assign status_wr = wr_fire && (wr_dec.sel == SEL_STATUS);

  always_comb begin
    irq_en = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      irq_en[n] = ctrl_q[n][CTRL_IRQ_EN];
    end
  end

  // A match on the same edge as a W1C write keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (match[n]) begin
          status_q[n] <= 1'b1;
        end else if (status_wr && s_wstrb[0] && s_wdata[n]) begin
          status_q[n] <= 1'b0;
        end
      end
    end
  end

  assign irq = |(status_q & irq_en);
`else
  logic unused_match;
  assign unused_match = ^match;
  assign irq          = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    if (rd_dec.sel == SEL_NONE) begin
      rd_resp = RESP_SLVERR;
    end else if (rd_dec.sel == SEL_STATUS) begin
`ifdef AXI_MULTI_TIMER_IRQ_EN
      rd_word = 32'(status_q);
`endif
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (rd_dec.ch == 4'(n)) begin
          case (rd_dec.sel)
            SEL_CTRL:     rd_word = 32'(ctrl_q[n]);
            SEL_COUNT:    rd_word = 32'(count[n]);
            SEL_PRESCALE: rd_word = 32'(prescale_q[n]);
            SEL_COMPARE:  rd_word = 32'(compare_q[n]);
            default:      rd_word = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else if (wr_fire) begin
      s_bvalid <= 1'b1;
      s_bresp  <= (wr_dec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (s_bvalid && s_bready) begin
      s_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (rd_fire) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_word;
      s_rresp  <= rd_resp;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule
